mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Multi-cycle sequencer for the processor's multiply operation. It accepts a multiply request from the execute stage and computes the 32-bit product of the lower 16 bits of each operand with a radix-2 shift-add loop. Fixed latency: one bit per cycle. It stalls the pipeline while working and returns a registered result with a one-cycle `done` pulse. It sits beside the ALU in EX and owns the sequencing, stall and flush handling for multiplies.

## Interface

- `OP_W`, 16, operand bits used from each source. The iteration count equals `OP_W`.
- `DATA_W`, 32, width of the operand and result buses.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: multiply request; `isMul` qualified by a valid instruction in EX.
- `flush` in 1: kill the in-flight operation (branch/exception flush).
- `A` in 32: operand A; only `A[OP_W-1:0]` is used.
- `B` in 32: operand B; only `B[OP_W-1:0]` is used.
- `busy` out 1: high while in RUN.
- `stall` out 1: pipeline hold request, combinational.
- `done` out 1: one-cycle pulse, high while in DONE.
- `result` out 32: registered product; holds its value until the next completion.

## Operation

**States**

- IDLE
- RUN: 16 iterations, with `cnt` counting 0..`OP_W-1`.
- DONE: one cycle.

**Transitions**

- IDLE → RUN when `start=1` and `flush=0`. On that edge:
  - `mcand` ← zero-extended `A[15:0]`, 32 bits
  - `mplr` ← `B[15:0]`
  - `acc` ← 0
  - `cnt` ← 0
- RUN, each cycle:
  - if `mplr[0]`, then `acc` ← `acc + mcand`, taken mod 2^32
  - `mcand` ← `mcand << 1`
  - `mplr` ← `mplr >> 1`
  - `cnt` ← `cnt + 1`
- RUN → DONE on the edge where `cnt == OP_W-1`. On that edge `result` ← final `acc`, including the last conditional add.
- DONE → IDLE unconditionally. `start` is not accepted in DONE.
  - `stall=0` in DONE, so the pipeline advances on that edge.
  - The next instruction's `start` is seen in IDLE.

**Flush and reset**

- `flush=1` in any state: next state is IDLE.
  - `done` is not asserted and `result` is unchanged.
  - `flush` has priority over `start` and over RUN → DONE.
- `reset=1`: next state is IDLE; `acc`, `mcand`, `mplr`, `cnt` and `result` all ← 0. Reset has priority over `flush` and `start`.

**Other rules**

- `start` asserted in RUN is ignored; A and B are not re-sampled.
- Arithmetic is unsigned. The maximum product is `0xFFFF*0xFFFF = 0xFFFE0001`, which fits in 32 bits with no overflow.
- Operand bits above `OP_W` never affect `result`.

## Timing

**Output values**

- Reset values: `busy=0`, `stall=0`, `done=0`, `result=0x00000000`.
- `busy = (state==RUN)`.
- `done = (state==DONE)`.
- `stall = (state==IDLE & start & ~flush) | (state==RUN)`.

**Latency**

- `start` is sampled at edge 0.
- RUN occupies cycles 1..16, with `busy=1` and `stall=1`.
- DONE is cycle 17: `done=1`, `result` valid, `stall=0`.
- Cycle 18 is IDLE.
- Total latency is `OP_W+1` cycles from acceptance to `done`.
- The pipeline sees `stall=1` for 17 cycles (cycle 0 through cycle 16).

**Throughput**

- One multiply per 18 cycles when requests are back-to-back: `start` at cycle 18, after DONE at cycle 17 and IDLE at cycle 18.

**Output stability**

- `result` changes only on the RUN → DONE edge or on reset.
- `result` is stable for every cycle in which `done=1`, and afterwards.

**Boundary cases**

- `flush` at cycle k in 1..16: IDLE at cycle k+1, and `done` never pulses.
- `flush` in the acceptance cycle: no acceptance, and `stall=0` in that cycle.
- `start=0` while IDLE: all outputs hold and `result` keeps its last product.

## Test plan

- **Basic multiply.** Reset, then `start` with `A=0x0000000A`, `B=0x00000005`.
  - `busy=1` for exactly 16 cycles.
  - `done` pulses at cycle 17 with `result=0x00000032`.
  - `stall` is high in cycles 0..16.
- **Upper bits ignored.** `A=0xABCD000A`, `B=0x12340005` → `result=0x00000032`.
  - Also: `A=0x000003E8`, `B=0x00000014` → `0x00004E20`.
- **Maximum and zero operands.**
  - `A=0x0000FFFF`, `B=0x0000FFFF` → `0xFFFE0001`.
  - `A=0`, `B=0x23` → `0x00000000`, with `done` still at cycle 17.
- **Start while busy.** Hold `start=1` with new operands (`A=7`, `B=3`) during RUN of a 10×5 operation.
  - Result is `0x32` at cycle 17; no re-sample.
  - `stall=0` in DONE.
  - Next `start` is accepted from IDLE and yields `0x15` 17 cycles later.
- **Flush mid-operation.** After a completed 10×5 (`result=0x32`), start `0xFFFF*0xFFFF` and assert `flush` at cycle 8.
  - IDLE at cycle 9, no `done`, `result` stays `0x32`, `stall=0` from cycle 9.
- **Reset mid-operation.** Assert `reset` at cycle 5 of a `0xFFFF*0xFFFF` operation.
  - Next cycle: `busy=0`, `stall=0`, `done=0`, `result=0x00000000`.
  - A subsequent 10×5 completes normally with `0x32`.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply sequencer.
// The master side issues requests and the slave side is the sequencer.
interface mul_seq_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic              flush;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              busy;
   logic              stall;
   logic              done;
   logic [DATA_W-1:0] result;

   modport master (
      output start, flush, A, B,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, flush, A, B,
      output busy, stall, done, result
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer for EX: one multiplier bit per cycle,
// holds the pipeline while running and returns a registered product.
module mul_seq_ctrl #(
   parameter int OP_W   = 16,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic reset,
   mul_seq_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(OP_W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t nstate;

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] accsum;
   logic [DATA_W-1:0] product;
   logic [OP_W-1:0]   mplr;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              lastiter;
   logic              unused_hibits;

   assign accept   = (state == IDLE) && bus.start && !bus.flush;
   assign lastiter = (cnt == CNT_W'(OP_W - 1));
   assign accsum   = mplr[0] ? (acc + mcand) : acc;

   // Only the low OP_W operand bits take part in the product.
   assign unused_hibits = ^{bus.A[DATA_W-1:OP_W], bus.B[DATA_W-1:OP_W]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      if (bus.flush) begin
         nstate = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) nstate = RUN;
            RUN:     if (lastiter) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
         endcase
      end
   end

   // A flushed iteration must not reach product; the final add is folded in
   // on the same edge that leaves RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         mcand   <= '0;
         mplr    <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         acc     <= '0;
         mcand   <= {{(DATA_W-OP_W){1'b0}}, bus.A[OP_W-1:0]};
         mplr    <= bus.B[OP_W-1:0];
         cnt     <= '0;
      end else if ((state == RUN) && !bus.flush) begin
         acc     <= accsum;
         mcand   <= mcand << 1;
         mplr    <= mplr >> 1;
         cnt     <= cnt + CNT_W'(1);
         if (lastiter) begin
            product <= accsum;
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.stall  = accept || (state == RUN);
   assign bus.result = product;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: per-cycle control checks plus a
// scoreboard of expected products popped whenever done pulses.
module tb_mul_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] sbq[$];

   always #5 clk = ~clk;

   mul_seq_ctrl_if #(.DATA_W(32)) intf ();

   mul_seq_ctrl #(.OP_W(16), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (intf)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // on the falling edge.
   task automatic applyStimulus(input logic r, input logic s, input logic f,
                                input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      reset      = r;
      intf.start = s;
      intf.flush = f;
      intf.A     = a;
      intf.B     = b;
   endtask

   task automatic test_reset;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({intf.busy, intf.stall, intf.done} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_ctrl busy/stall/done=%b expected 000", {intf.busy, intf.stall, intf.done});
      end
      checks++;
      if (intf.result !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_result got %h expected 00000000", intf.result);
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
         @(negedge clk);
         checks++;
         if ({intf.busy, intf.stall, intf.done, intf.result} !== {3'b000, 32'h0}) begin
            failures++;
            $display("[TB] FAIL idle_hold cyc=%0d ctrl=%b result=%h expected 000/00000000", c, {intf.busy, intf.stall, intf.done}, intf.result);
         end
      end
   endtask

   task automatic test_multiply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      logic [2:0] want;
      for (int c = 0; c <= 18; c++) begin
         if (c == 0) begin
            applyStimulus(1'b0, 1'b1, 1'b0, a, b);
            sbq.push_back(exp);
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, ~a, ~b);
         end
         @(negedge clk);
         want = {(c >= 1 && c <= 16), (c <= 16), (c == 17)};
         checks++;
         if ({intf.busy, intf.stall, intf.done} !== want) begin
            failures++;
            $display("[TB] FAIL mul_ctrl a=%h b=%h cyc=%0d busy/stall/done=%b expected %b", a, b, c, {intf.busy, intf.stall, intf.done}, want);
         end
         if (intf.done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("[TB] FAIL mul_result unexpected done cyc=%0d result=%h expected no done", c, intf.result);
            end else begin
               logic [31:0] e;
               e = sbq.pop_front();
               if (intf.result !== e) begin
                  failures++;
                  $display("[TB] FAIL mul_result a=%h b=%h got %h expected %h", a, b, intf.result, e);
               end
            end
         end
      end
      checks++;
      if (intf.result !== exp) begin
         failures++;
         $display("[TB] FAIL result_hold got %h expected %h", intf.result, exp);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] want;
      for (int c = 0; c <= 36; c++) begin
         applyStimulus(1'b0, (c <= 18), 1'b0, (c == 0) ? 32'd10 : 32'd7, (c == 0) ? 32'd5 : 32'd3);
         if (c == 0)  sbq.push_back(32'h0000_0032);
         if (c == 18) sbq.push_back(32'h0000_0015);
         @(negedge clk);
         want = {((c >= 1 && c <= 16) || (c >= 19 && c <= 34)),
                 ((c <= 16) || (c >= 18 && c <= 34)),
                 ((c == 17) || (c == 35))};
         checks++;
         if ({intf.busy, intf.stall, intf.done} !== want) begin
            failures++;
            $display("[TB] FAIL b2b_ctrl cyc=%0d busy/stall/done=%b expected %b", c, {intf.busy, intf.stall, intf.done}, want);
         end
         if (intf.done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("[TB] FAIL b2b_result unexpected done cyc=%0d result=%h expected no done", c, intf.result);
            end else begin
               logic [31:0] e;
               e = sbq.pop_front();
               if (intf.result !== e) begin
                  failures++;
                  $display("[TB] FAIL b2b_result cyc=%0d got %h expected %h", c, intf.result, e);
               end
            end
         end
      end
   endtask

   task automatic test_flush;
      logic [2:0] want;
      test_multiply(32'd10, 32'd5, 32'h0000_0032);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF);
      @(negedge clk);
      checks++;
      if ({intf.busy, intf.stall} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL flush_accept_stall busy/stall=%b expected 00", {intf.busy, intf.stall});
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
      @(negedge clk);
      checks++;
      if ({intf.busy, intf.stall, intf.done} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL flush_accept_idle busy/stall/done=%b expected 000", {intf.busy, intf.stall, intf.done});
      end
      for (int c = 0; c <= 20; c++) begin
         applyStimulus(1'b0, (c == 0), (c == 8), 32'h0000_FFFF, 32'h0000_FFFF);
         @(negedge clk);
         want = {(c >= 1 && c <= 8), (c <= 8), 1'b0};
         checks++;
         if ({intf.busy, intf.stall, intf.done} !== want || intf.result !== 32'h0000_0032) begin
            failures++;
            $display("[TB] FAIL flush_mid cyc=%0d busy/stall/done=%b result=%h expected %b/00000032", c, {intf.busy, intf.stall, intf.done}, intf.result, want);
         end
      end
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c <= 6; c++) begin
         applyStimulus((c == 5), (c == 0), 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
         @(negedge clk);
         checks++;
         if (c <= 5) begin
            if ({intf.busy, intf.stall, intf.done} !== {(c >= 1), 2'b10} || intf.result !== 32'h0000_0032) begin
               failures++;
               $display("[TB] FAIL reset_mid_run cyc=%0d busy/stall/done=%b result=%h expected %b/00000032", c, {intf.busy, intf.stall, intf.done}, intf.result, {(c >= 1), 2'b10});
            end
         end else begin
            if ({intf.busy, intf.stall, intf.done, intf.result} !== {3'b000, 32'h0}) begin
               failures++;
               $display("[TB] FAIL reset_mid_after busy/stall/done=%b result=%h expected 000/00000000", {intf.busy, intf.stall, intf.done}, intf.result);
            end
         end
      end
      test_multiply(32'd10, 32'd5, 32'h0000_0032);
   endtask

   initial begin
      reset      = 1'b1;
      intf.start = 1'b0;
      intf.flush = 1'b0;
      intf.A     = '0;
      intf.B     = '0;

      test_reset();
      test_multiply(32'h0000_000A, 32'h0000_0005, 32'h0000_0032);
      test_multiply(32'hABCD_000A, 32'h1234_0005, 32'h0000_0032);
      test_multiply(32'h0000_03E8, 32'h0000_0014, 32'h0000_4E20);
      test_multiply(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
      test_multiply(32'h0000_0000, 32'h0000_0023, 32'h0000_0000);
      test_back_to_back();
      test_flush();
      test_reset_mid();

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain pending=%0d expected 0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
